regfile_piso: RTL and testbench
===============================

Name: regfile_piso

Overview:
Parallel-in, serial-out register file: 128 x 32-bit storage. One write writes five consecutive words in a single cycle. Reads stream out one word per cycle through a valid/ready burst port. Acts as the burst-write, streaming-read counterpart of the serial-in, parallel-out register file; it feeds downstream serial consumers from wide producers.

Parameters:
DataSize, 32, word width in bits
AddrSize, 7, address width; depth = 2^AddrSize = 128
BurstMax, 5, words per parallel write and maximum words per read burst

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
reg_enable  input  1  global enable; 0 freezes writes, FSM, and output register
reg_write  input  1  parallel-write strobe, qualified by reg_enable
write_addr  input  AddrSize  base address of the 5-word write
write_data1..write_data5  input  DataSize each  words for base+0 .. base+4
rd_start  input  1  burst request, qualified by reg_enable, accepted only in IDLE
src_addr  input  AddrSize  first address of the read burst
rd_len  input  3  burst length; values 1..5 used as given, 0 and 6..7 clamp to 5
read_data  output  DataSize  current streamed word (registered)
read_valid  output  1  read_data valid
read_ready  input  1  consumer accepts word when read_valid & read_ready
read_last  output  1  current word is the final word of the burst
busy  output  1  FSM in BURST

Behaviour:
- Reset (rst=1 at a clk edge; overrides everything, including reg_enable=0):
  - all 128 REG entries <= 0
  - read_data=0, read_valid=0, read_last=0, busy=0
  - FSM <= IDLE, internal pointer/counter <= 0
  - mid-burst reset aborts the burst; no further words are output.
- reg_enable=0: no state changes at all (REG, FSM, outputs, pointer). Outputs hold; handshakes are not counted.
- Write (reg_enable & reg_write): REG[(write_addr+k) mod 128] <= write_data(k+1) for k=0..4.
  - Wrap-around: write_addr=126 writes entries 126, 127, 0, 1, 2.
  - Legal in any FSM state.
- FSM states: IDLE, BURST.
  - IDLE -> BURST on reg_enable & rd_start.
    - ptr <= src_addr+1; remaining <= clamp(rd_len)-1
    - read_data <= REG[src_addr]; read_valid <= 1; busy <= 1
    - read_last <= (clamp(rd_len)==1)
    - Latency: first word is valid on the cycle after the start is accepted.
  - In BURST, rd_start is ignored.
  - BURST with read_valid & !read_ready: read_data and read_last hold.
  - BURST with handshake and remaining>0:
    - read_data <= REG[ptr]; ptr <= ptr+1 (mod 128); remaining <= remaining-1
    - read_last <= (remaining==1)
  - BURST with handshake and read_last=1 -> IDLE: read_valid <= 0, read_last <= 0, busy <= 0.
    - read_data holds its last value.
    - A new rd_start is accepted the following cycle at the earliest.
- Throughput: one word per cycle while read_ready=1.
- Read addresses wrap mod 128: src_addr=127, len 3 reads 127, 0, 1.
- Same-edge write and read-load of the same address: the output register captures the pre-write (old) contents. The new value is visible to later loads.

Optional Feature:
PARITY_EN
- Defined:
  - Adds output read_parity (1 bit) = XOR of the word being loaded into read_data, registered with it.
  - read_parity holds with read_data and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset and readback: assert rst for 1 cycle, then read bursts covering all 128 entries -> every word = 0; read_valid=0 and busy=0 immediately after reset.
- Parallel write with wrap: write_addr=126, data 32'hffff_0000..32'hffff_0004; burst src_addr=126, rd_len=5, read_ready=1 -> words ffff_0000..ffff_0004 on 5 consecutive cycles; read_last only on the 5th; busy drops the cycle after.
- Backpressure: burst src_addr=0, len 3 after writing 0..2 = 1, 2, 3; read_ready low 2 cycles on word 2 -> read_data=2 held; sequence 1, 2, 3 with no duplicates or drops.
- Length clamp and ignored start: rd_len=0 from addr 120 -> exactly 5 words (120..124); a rd_start pulse mid-burst with src_addr=7 -> no effect.
- Enable freeze and reset mid-burst: reg_enable=0 for 3 cycles mid-burst -> outputs frozen and writes ignored; then rst mid-burst -> read_valid=0 next cycle, REG cleared.
- Same-edge collision: word at addr 10 = 5; write 32'hAAAA at base 10 on the same edge that loads addr 10 -> streamed value 5; a subsequent burst returns 32'hAAAA. With PARITY_EN: read_data 32'h0000_0007 -> read_parity=1.

Source files
------------

// File: rtl/regfile_piso.sv
`default_nettype none
// ============================================================================
// Module   : regfile_piso
// Purpose  : Parallel-in, serial-out register file. 128 x 32-bit storage.
//            A single write strobe stores five consecutive words (address
//            wraps mod 128). Reads stream one word per cycle through a
//            registered valid/ready burst port of 1..5 words.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            reg_enable          - global enable, 0 freezes all state
//            reg_write           - five-word parallel write strobe
//            write_addr          - base address of the write
//            write_data1..5      - words for base+0 .. base+4
//            rd_start            - burst request (accepted only when idle)
//            src_addr            - first address of the burst
//            rd_len              - burst length, 0 and 6..7 clamp to 5
//            read_data           - streamed word (registered)
//            read_valid          - read_data valid
//            read_ready          - consumer accepts the current word
//            read_last           - current word ends the burst
//            busy                - a burst is in progress
//            read_parity         - XOR of read_data (PARITY_EN builds only)
// Options  : define PARITY_EN to add the read_parity output.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_piso #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 7,
  parameter int BURST_MAX = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_enable,
  input  logic                 reg_write,
  input  logic [ADDR_SIZE-1:0] write_addr,
  input  logic [DATA_SIZE-1:0] write_data1,
  input  logic [DATA_SIZE-1:0] write_data2,
  input  logic [DATA_SIZE-1:0] write_data3,
  input  logic [DATA_SIZE-1:0] write_data4,
  input  logic [DATA_SIZE-1:0] write_data5,
  input  logic                 rd_start,
  input  logic [ADDR_SIZE-1:0] src_addr,
  input  logic [2:0]           rd_len,
  output logic [DATA_SIZE-1:0] read_data,
  output logic                 read_valid,
  input  logic                 read_ready,
  output logic                 read_last,
  output logic                 busy
`ifdef PARITY_EN
  ,
  output logic                 read_parity
`endif
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [DATA_SIZE-1:0] wdata [BURST_MAX];
  logic [ADDR_SIZE-1:0] ptr;
  logic [2:0]           remaining;
  logic [2:0]           len_clamped;
  logic [DATA_SIZE-1:0] load_word;

  assign wdata[0] = write_data1;
  assign wdata[1] = write_data2;
  assign wdata[2] = write_data3;
  assign wdata[3] = write_data4;
  assign wdata[4] = write_data5;

  // Lengths outside 1..BURST_MAX mean "a full burst".
  assign len_clamped = (rd_len == 3'd0 || rd_len > 3'(BURST_MAX)) ?
                       3'(BURST_MAX) : rd_len;

  // Word entering the output register: the burst head when starting,
  // otherwise the running pointer.
  assign load_word = (state == IDLE) ? mem[src_addr] : mem[ptr];

  // Storage. Reads in the FSM block sample the pre-edge contents, so a
  // same-edge write and load of one address returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (reg_enable && reg_write) begin
      for (int k = 0; k < BURST_MAX; k++) begin
        mem[write_addr + ADDR_SIZE'(k)] <= wdata[k];
      end
    end
  end

  // Burst FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      read_last  <= 1'b0;
      busy       <= 1'b0;
`ifdef PARITY_EN
      read_parity <= 1'b0;
`endif
    end else if (reg_enable) begin
      case (state)
        IDLE: begin
          if (rd_start) begin
            state      <= BURST;
            ptr        <= src_addr + 1'b1;
            remaining  <= len_clamped - 3'd1;
            read_data  <= load_word;
            read_valid <= 1'b1;
            read_last  <= (len_clamped == 3'd1);
            busy       <= 1'b1;
`ifdef PARITY_EN
            read_parity <= ^load_word;
`endif
          end
        end
        BURST: begin
          if (read_valid && read_ready) begin
            if (remaining != 3'd0) begin
              read_data <= load_word;
              ptr       <= ptr + 1'b1;
              remaining <= remaining - 3'd1;
              read_last <= (remaining == 3'd1);
`ifdef PARITY_EN
              read_parity <= ^load_word;
`endif
            end else begin
              // Final word accepted; read_data keeps its last value.
              state      <= IDLE;
              read_valid <= 1'b0;
              read_last  <= 1'b0;
              busy       <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_piso.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_piso
// Purpose  : Directed self-checking bench for regfile_piso. A shadow array
//            holds the expected storage contents; every output is checked
//            with an immediate assertion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_piso;

  logic        clk;
  logic        rst;
  logic        reg_enable;
  logic        reg_write;
  logic [6:0]  write_addr;
  logic [31:0] write_data1, write_data2, write_data3, write_data4, write_data5;
  logic        rd_start;
  logic [6:0]  src_addr;
  logic [2:0]  rd_len;
  logic [31:0] read_data;
  logic        read_valid;
  logic        read_ready;
  logic        read_last;
  logic        busy;
`ifdef PARITY_EN
  logic        read_parity;
`endif

  int          n_checks;
  int          n_fail;
  logic [31:0] model [128];

  regfile_piso dut (
    .clk         (clk),
    .rst         (rst),
    .reg_enable  (reg_enable),
    .reg_write   (reg_write),
    .write_addr  (write_addr),
    .write_data1 (write_data1),
    .write_data2 (write_data2),
    .write_data3 (write_data3),
    .write_data4 (write_data4),
    .write_data5 (write_data5),
    .rd_start    (rd_start),
    .src_addr    (src_addr),
    .rd_len      (rd_len),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .read_ready  (read_ready),
    .read_last   (read_last),
    .busy        (busy)
`ifdef PARITY_EN
    ,
    .read_parity (read_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, read_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},       32'd0);
    chk({tag, "_last"},  {31'd0, read_last},  32'd0);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [31:0] d1, d2, d3, d4, d5);
    reg_write   = 1'b1;
    write_addr  = a;
    write_data1 = d1; write_data2 = d2; write_data3 = d3;
    write_data4 = d4; write_data5 = d5;
    tick();
    reg_write = 1'b0;
    model[7'(a + 7'd0)] = d1;
    model[7'(a + 7'd1)] = d2;
    model[7'(a + 7'd2)] = d3;
    model[7'(a + 7'd3)] = d4;
    model[7'(a + 7'd4)] = d5;
  endtask

  // Full-rate burst; n is the number of words the length should produce.
  task automatic do_read(input string tag, input logic [6:0] src, input logic [2:0] len, input int n);
    rd_start   = 1'b1;
    src_addr   = src;
    rd_len     = len;
    read_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, {31'd0, read_valid}, 32'd1);
      chk({tag, "_data"},  read_data, model[7'(src + 7'(i))]);
      chk({tag, "_last"},  {31'd0, read_last}, (i == n - 1) ? 32'd1 : 32'd0);
      chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
      tick();
    end
    chk_idle({tag, "_end"});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 128; i++) model[i] = 32'd0;
    rst = 1'b1; reg_enable = 1'b0; reg_write = 1'b0; write_addr = '0;
    write_data1 = '0; write_data2 = '0; write_data3 = '0;
    write_data4 = '0; write_data5 = '0;
    rd_start = 1'b0; src_addr = '0; rd_len = '0; read_ready = 1'b1;

    // Reset wins even with the enable low.
    tick();
    rst = 1'b0;
    reg_enable = 1'b1;
    chk_idle("reset");
    chk("reset_data", read_data, 32'd0);

    // Every entry reads back as zero.
    for (int b = 0; b < 26; b++) begin
      do_read("zero", 7'(b * 5), 3'd5, 5);
    end

    // Parallel write wrapping past the top of the array.
    do_write(7'd126, 32'hffff_0000, 32'hffff_0001, 32'hffff_0002, 32'hffff_0003, 32'hffff_0004);
    chk("wrap_model", model[1], 32'hffff_0003);
    do_read("wrap", 7'd126, 3'd5, 5);

    // Backpressure on the second word.
    do_write(7'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    rd_start = 1'b1; src_addr = 7'd0; rd_len = 3'd3; read_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("bp_w0", read_data, 32'd1);
    tick();
    chk("bp_w1", read_data, 32'd2);
    read_ready = 1'b0;
    tick();
    chk("bp_hold1", read_data, 32'd2);
    chk("bp_hold1_valid", {31'd0, read_valid}, 32'd1);
    tick();
    chk("bp_hold2", read_data, 32'd2);
    chk("bp_hold2_last", {31'd0, read_last}, 32'd0);
    read_ready = 1'b1;
    tick();
    chk("bp_w2", read_data, 32'd3);
    chk("bp_w2_last", {31'd0, read_last}, 32'd1);
    tick();
    chk_idle("bp_end");
    chk("bp_data_hold", read_data, 32'd3);

    // rd_len=0 clamps to 5; a start pulse mid-burst is ignored.
    do_write(7'd120, 32'h120, 32'h121, 32'h122, 32'h123, 32'h124);
    rd_start = 1'b1; src_addr = 7'd120; rd_len = 3'd0;
    tick();
    src_addr = 7'd7; rd_len = 3'd1;
    for (int i = 0; i < 5; i++) begin
      chk("clamp_data", read_data, 32'h120 + 32'(i));
      chk("clamp_last", {31'd0, read_last}, (i == 4) ? 32'd1 : 32'd0);
      if (i == 4) rd_start = 1'b0;
      tick();
    end
    chk_idle("clamp_end");

    // Length 6 clamps to 5, length 1 gives a single word.
    do_read("len6", 7'd120, 3'd6, 5);
    do_read("len1", 7'd122, 3'd1, 1);

    // Enable freeze mid-burst, then reset mid-burst.
    do_write(7'd40, 32'h40, 32'h41, 32'h42, 32'h43, 32'h44);
    rd_start = 1'b1; src_addr = 7'd40; rd_len = 3'd4;
    tick();
    rd_start = 1'b0;
    chk("frz_w0", read_data, 32'h40);
    tick();
    chk("frz_w1", read_data, 32'h41);
    reg_enable = 1'b0;
    reg_write = 1'b1; write_addr = 7'd40;
    write_data1 = 32'hdead_0000; write_data2 = 32'hdead_0001; write_data3 = 32'hdead_0002;
    write_data4 = 32'hdead_0003; write_data5 = 32'hdead_0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_data",  read_data, 32'h41);
      chk("frz_valid", {31'd0, read_valid}, 32'd1);
      chk("frz_busy",  {31'd0, busy}, 32'd1);
      chk("frz_last",  {31'd0, read_last}, 32'd0);
    end
    reg_write = 1'b0;
    reg_enable = 1'b1;
    tick();
    chk("frz_w2", read_data, 32'h42);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 128; i++) model[i] = 32'd0;
    chk_idle("midrst");
    chk("midrst_data", read_data, 32'd0);
    tick();
    chk_idle("midrst_after");
    do_read("midrst_clr", 7'd40, 3'd5, 5);
    do_read("midrst_clr2", 7'd126, 3'd3, 3);

    // Same-edge write and load of one address returns the old word.
    do_write(7'd10, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9);
    rd_start = 1'b1; src_addr = 7'd10; rd_len = 3'd1;
    reg_write = 1'b1; write_addr = 7'd10;
    write_data1 = 32'hAAAA; write_data2 = 32'hAAAB; write_data3 = 32'hAAAC;
    write_data4 = 32'hAAAD; write_data5 = 32'hAAAE;
    tick();
    rd_start = 1'b0; reg_write = 1'b0;
    chk("coll_old", read_data, 32'd5);
    chk("coll_last", {31'd0, read_last}, 32'd1);
    model[10] = 32'hAAAA; model[11] = 32'hAAAB; model[12] = 32'hAAAC;
    model[13] = 32'hAAAD; model[14] = 32'hAAAE;
    tick();
    chk_idle("coll_end");
    do_read("coll_new", 7'd10, 3'd2, 2);

`ifdef PARITY_EN
    do_write(7'd20, 32'h0000_0007, 32'h0000_0003, 32'd0, 32'd0, 32'd0);
    rd_start = 1'b1; src_addr = 7'd20; rd_len = 3'd2; read_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("par_w0", {31'd0, read_parity}, 32'd1);
    tick();
    chk("par_w1", {31'd0, read_parity}, 32'd0);
    tick();
    chk_idle("par_end");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
